// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and instruction memory.
// One request outstanding at most; the response strobe arrives one or more cycles later.
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               IMemReq;
  logic [ADDR_W-1:0]  IMemAddr;
  logic [INSTR_W-1:0] IMemRdata;
  logic               IMemValid;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemRdata,
    input  IMemValid
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemRdata,
    output IMemValid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns PCF, keeps one instruction-memory request in flight and
// drives the IF/ID register, turning memory latency into bubbles rather than stalls.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               BranchTakenE,
  input  logic [ADDR_W-1:0]  ALUResultE,
  input  logic               PCSrcW,
  input  logic [ADDR_W-1:0]  ResultW,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] InstrD,
  output logic [ADDR_W-1:0]  PCPlus4D,
  output logic               ValidD
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pend_q, pend_d;
  logic               discard_q, discard_d;
  logic [INSTR_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0]  buf_pc_q, buf_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;
  logic               valid_q, valid_d;

  logic               redirect;
  logic [ADDR_W-1:0]  target;
  logic               keep_rsp;
  logic               req;
  logic               deliver;
  logic [INSTR_W-1:0] dlv_instr;
  logic [ADDR_W-1:0]  dlv_pc4;

  always_comb begin
    redirect  = BranchTakenE | PCSrcW;
    target    = BranchTakenE ? ALUResultE : ResultW;
    // A response is only worth keeping if nothing has made it stale.
    keep_rsp  = imem.IMemValid & ~discard_q & ~redirect & ~FlushD;

    state_d   = state_q;
    pend_d    = pend_q;
    discard_d = discard_q;
    buf_d     = buf_q;
    buf_pc_d  = buf_pc_q;
    req       = 1'b0;
    deliver   = 1'b0;
    dlv_instr = '0;
    dlv_pc4   = '0;

    unique case (state_q)
      StReq: begin
        if (!redirect && !StallF) begin
          req     = 1'b1;
          pend_d  = pc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem.IMemValid) begin
          discard_d = 1'b0;
          if (!keep_rsp) begin
            state_d = StReq;
          end else if (StallD) begin
            buf_d    = imem.IMemRdata;
            buf_pc_d = pend_q + ADDR_W'(4);
            state_d  = StHold;
          end else begin
            deliver   = 1'b1;
            dlv_instr = imem.IMemRdata;
            dlv_pc4   = pend_q + ADDR_W'(4);
            // Back-to-back issue keeps latency-1 memory at full throughput.
            if (!StallF) begin
              req    = 1'b1;
              pend_d = pc_q;
            end else begin
              state_d = StReq;
            end
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect || FlushD) begin
          buf_d    = '0;
          buf_pc_d = '0;
          state_d  = StReq;
        end else if (!StallD) begin
          deliver   = 1'b1;
          dlv_instr = buf_q;
          dlv_pc4   = buf_pc_q;
          state_d   = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    if (redirect) begin
      pc_d = target;
    end else if (req) begin
      pc_d = pc_q + ADDR_W'(4);
    end else begin
      pc_d = pc_q;
    end

    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (deliver) begin
      instr_d = dlv_instr;
      pc4_d   = dlv_pc4;
      valid_d = 1'b1;
    end else if (FlushD || !StallD) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StReq;
      pc_q      <= RESET_PC;
      pend_q    <= '0;
      discard_q <= 1'b0;
      buf_q     <= '0;
      buf_pc_q  <= '0;
      instr_q   <= '0;
      pc4_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      discard_q <= discard_d;
      buf_q     <= buf_d;
      buf_pc_q  <= buf_pc_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      valid_q   <= valid_d;
    end
  end

  assign imem.IMemReq  = req & ~rst;
  assign imem.IMemAddr = pc_q;
  assign InstrD        = instr_q;
  assign PCPlus4D      = pc4_q;
  assign ValidD        = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-programmable instruction memory plus a scoreboard that
// tracks the expected fetch address and the fate of every returned instruction.
module tb_fetch_stage;
  localparam logic [31:0] ResetPc = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, BranchTakenE, PCSrcW;
  logic [31:0] ALUResultE, ResultW;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD;

  fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) imem_bus ();

  fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(ResetPc)) dut (
    .clk          (clk),
    .rst          (rst),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .BranchTakenE (BranchTakenE),
    .ALUResultE   (ALUResultE),
    .PCSrcW       (PCSrcW),
    .ResultW      (ResultW),
    .imem         (imem_bus),
    .InstrD       (InstrD),
    .PCPlus4D     (PCPlus4D),
    .ValidD       (ValidD)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: next fetch address, expected IF/ID contents, memory and buffered word.
  logic [31:0] exp_pc, exp_instr, exp_pc4, held_addr, mem_addr;
  bit          exp_valid, chk_pc4, held, dead, mem_busy;
  int          mem_cnt, min_lat, max_lat;
  bit          rnd_mode;
  bit          inj_pending, inj_br, inj_ps;
  logic [31:0] inj_bt, inj_pt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0200;
      1:       return 32'h0000_0300;
      2:       return 32'hFFFF_FFF8;
      default: return r & ~32'h3;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc    = ResetPc;
    exp_valid = 1'b0;
    exp_instr = '0;
    exp_pc4   = '0;
    chk_pc4   = 1'b1;
    held      = 1'b0;
    dead      = 1'b0;
    mem_busy  = 1'b0;
    mem_cnt   = 0;
    mem_addr  = '0;
  endtask

  task automatic inject(input bit br, input logic [31:0] bt, input bit ps, input logic [31:0] pt);
    inj_pending = 1'b1;
    inj_br      = br;
    inj_bt      = bt;
    inj_ps      = ps;
    inj_pt      = pt;
  endtask

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic run_cycle();
    bit          redirect, keep, dlv, exp_req;
    logic [31:0] tgt, dlv_addr;
    ALUResultE = pick_target();
    ResultW    = pick_target();
    if (inj_pending) begin
      StallF = 0; StallD = 0; FlushD = 0;
      BranchTakenE = inj_br; ALUResultE = inj_bt;
      PCSrcW = inj_ps; ResultW = inj_pt;
      inj_pending = 1'b0;
    end else if (rnd_mode) begin
      StallF       = ($urandom_range(0, 3) == 0);
      StallD       = ($urandom_range(0, 3) == 0);
      FlushD       = ($urandom_range(0, 9) == 0);
      BranchTakenE = ($urandom_range(0, 11) == 0);
      PCSrcW       = ($urandom_range(0, 11) == 0);
    end else begin
      StallF = 0; StallD = 0; FlushD = 0; BranchTakenE = 0; PCSrcW = 0;
    end
    imem_bus.IMemValid = 1'b0;
    imem_bus.IMemRdata = $urandom();
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        imem_bus.IMemValid = 1'b1;
        imem_bus.IMemRdata = mem_word(mem_addr);
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end

    @(negedge clk);
    redirect = BranchTakenE | PCSrcW;
    tgt      = BranchTakenE ? ALUResultE : ResultW;
    keep     = imem_bus.IMemValid && !dead && !redirect && !FlushD;
    exp_req  = !redirect && !StallF && !held && !mem_busy &&
               (!imem_bus.IMemValid || (keep && !StallD));
    check_eq("imem_req", {31'd0, imem_bus.IMemReq}, {31'd0, exp_req});
    if (exp_req && imem_bus.IMemReq) check_eq("imem_addr", imem_bus.IMemAddr, exp_pc);

    dlv      = 1'b0;
    dlv_addr = '0;
    if (held) begin
      if (redirect || FlushD) held = 1'b0;
      else if (!StallD) begin dlv = 1'b1; dlv_addr = held_addr; held = 1'b0; end
    end
    if (imem_bus.IMemValid) begin
      if (keep && StallD) begin held = 1'b1; held_addr = mem_addr; end
      else if (keep) begin dlv = 1'b1; dlv_addr = mem_addr; end
    end else if (mem_busy && redirect) begin
      dead = 1'b1;
    end

    if (dlv) begin
      exp_valid = 1'b1; exp_instr = mem_word(dlv_addr); exp_pc4 = dlv_addr + 32'd4; chk_pc4 = 1'b1;
    end else if (FlushD) begin
      exp_valid = 1'b0; exp_instr = '0; exp_pc4 = '0; chk_pc4 = 1'b1;
    end else if (!StallD) begin
      exp_valid = 1'b0; exp_instr = '0; chk_pc4 = 1'b0;
    end

    if (redirect) exp_pc = tgt;
    else if (exp_req) exp_pc = exp_pc + 32'd4;
    if (imem_bus.IMemReq) begin
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(min_lat, max_lat);
      mem_addr = imem_bus.IMemAddr;
      dead     = 1'b0;
    end

    @(posedge clk);
    #1;
    check_eq("valid_d", {31'd0, ValidD}, {31'd0, exp_valid});
    check_eq("instr_d", InstrD, exp_instr);
    if (chk_pc4) check_eq("pc_plus4_d", PCPlus4D, exp_pc4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    StallF = 0; StallD = 0; FlushD = 0; BranchTakenE = 0; PCSrcW = 0;
    ALUResultE = '0; ResultW = '0;
    imem_bus.IMemValid = 1'b0;
    imem_bus.IMemRdata = '0;
    min_lat = 1; max_lat = 1; rnd_mode = 1'b0; inj_pending = 1'b0;
    model_reset();

    #2;
    check_eq("rst_imem_req", {31'd0, imem_bus.IMemReq}, 32'd0);
    check_eq("rst_valid_d", {31'd0, ValidD}, 32'd0);
    check_eq("rst_instr_d", InstrD, 32'd0);
    check_eq("rst_pc_plus4_d", PCPlus4D, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency 1, no stalls: full throughput from RESET_PC.
    repeat (12) run_cycle();

    // Latency 3, then a branch and PC write in the same cycle (branch must win).
    min_lat = 3; max_lat = 3;
    repeat (13) run_cycle();
    inject(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300);
    repeat (12) run_cycle();

    // Sequential fetch across the top of the address space.
    min_lat = 1; max_lat = 1;
    inject(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0000_0300);
    repeat (6) run_cycle();

    // Random stalls, flushes, redirects and latencies.
    rnd_mode = 1'b1; min_lat = 1; max_lat = 4;
    repeat (3000) run_cycle();

    // Asynchronous reset while a request is outstanding.
    rnd_mode = 1'b0; min_lat = 3; max_lat = 3;
    for (int i = 0; i < 10 && !mem_busy; i++) run_cycle();
    check_eq("reach_wait", {31'd0, mem_busy}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("midrst_imem_req", {31'd0, imem_bus.IMemReq}, 32'd0);
    check_eq("midrst_valid_d", {31'd0, ValidD}, 32'd0);
    check_eq("midrst_instr_d", InstrD, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_bus.IMemValid = 1'b0;
    model_reset();
    repeat (10) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
